// File: rtl/hwpe_sel_ctrl.sv
// Selection and clock-enable sequencer for a multi-HWPE subsystem: switches
// sel_o only after config traffic has drained and the active HWPE is idle.
//
//   state  | meaning
//   OFF    | all HWPE clocks gated, waiting for an enable with a valid select
//   WAKE   | selected clock running, config traffic held off for WAKE_CYCLES
//   ACTIVE | config traffic forwarded to the selected HWPE
//   DRAIN  | new requests blocked, waiting for responses and HWPE idle
//   GATE   | one cycle with every clock enable low before reselecting
module hwpe_sel_ctrl #(
    parameter int unsigned N_HWPES         = 4,
    parameter int unsigned SEL_W           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned WAKE_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hwpe_en_i,
    input  logic [SEL_W-1:0]   hwpe_sel_i,
    input  logic [N_HWPES-1:0] busy_i,
    input  logic               cfg_req_i,
    output logic               cfg_gnt_o,
    output logic               cfg_req_o,
    input  logic               cfg_gnt_i,
    input  logic               cfg_r_valid_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic [N_HWPES-1:0] hwpe_clk_en_o,
    output logic               busy_o,
    output logic               ready_o,
    output logic               sel_err_o
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_WAKE   = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_GATE   = 3'd4;

    localparam logic [CNT_W-1:0]  MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WAKE_W-1:0] WAKE_INIT = WAKE_W'(WAKE_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_HWPES-1:0] clk_en_q, clk_en_d;
    logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               err_q, err_d;

    logic               sel_valid;
    logic               underflow;
    logic               busy_sel;
    logic [N_HWPES-1:0] req_onehot;
    logic [N_HWPES-1:0] cur_onehot;

    assign sel_valid = (32'(hwpe_sel_i) < N_HWPES);

    // Decoders are built by compare rather than by indexing so that any
    // SEL_W wider than needed for N_HWPES stays safe.
    always_comb begin
        req_onehot = '0;
        cur_onehot = '0;
        for (int unsigned i = 0; i < N_HWPES; i++) begin
            req_onehot[i] = (32'(hwpe_sel_i) == i);
            cur_onehot[i] = (32'(sel_q) == i);
        end
    end

    assign busy_sel  = |(busy_i & cur_onehot);
    assign cfg_req_o = cfg_req_i && (state_q == ST_ACTIVE) && (out_cnt_q < MAX_OUT);
    assign cfg_gnt_o = cfg_req_o && cfg_gnt_i;

    always_comb begin
        out_cnt_d = out_cnt_q;
        underflow = 1'b0;
        if (cfg_gnt_o && !cfg_r_valid_i) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!cfg_gnt_o && cfg_r_valid_i) begin
            if (out_cnt_q == '0) underflow = 1'b1;
            else                 out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    assign err_d = err_q | underflow | (hwpe_en_i && !sel_valid);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        clk_en_d   = clk_en_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_OFF, ST_GATE: begin
                clk_en_d = '0;
                if (hwpe_en_i && sel_valid) begin
                    state_d    = ST_WAKE;
                    sel_d      = hwpe_sel_i;
                    clk_en_d   = req_onehot;
                    wake_cnt_d = WAKE_INIT;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == '0) state_d = ST_ACTIVE;
                else                  wake_cnt_d = wake_cnt_q - WAKE_W'(1);
            end
            ST_ACTIVE: begin
                if (!hwpe_en_i || (sel_valid && hwpe_sel_i != sel_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A reverted request wins over a completed drain: no needless gate cycle.
                if (hwpe_en_i && hwpe_sel_i == sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (out_cnt_q == '0 && !busy_sel) begin
                    state_d  = ST_GATE;
                    clk_en_d = '0;
                end
            end
            default: begin
                state_d  = ST_OFF;
                clk_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            sel_q      <= '0;
            clk_en_q   <= '0;
            wake_cnt_q <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            clk_en_q   <= clk_en_d;
            wake_cnt_q <= wake_cnt_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
        end
    end

    assign sel_o         = sel_q;
    assign hwpe_clk_en_o = clk_en_q;
    assign sel_err_o     = err_q;
    assign ready_o       = (state_q == ST_ACTIVE);
    assign busy_o        = (state_q == ST_WAKE) || (state_q == ST_DRAIN) || (state_q == ST_GATE)
                        || ((state_q == ST_ACTIVE) && busy_sel) || (out_cnt_q != '0);

endmodule

// File: doc/hwpe_sel_ctrl.md
Name: hwpe_sel_ctrl

Overview:
Sequential selection and clock-enable controller for a multi-HWPE subsystem with N_HWPES accelerators.
- Turns the raw enable/select inputs into a registered, glitch-safe active selection (sel_o) and a one-hot per-HWPE clock enable.
- Before changing sel_o it drains outstanding config-bus transactions and waits for the active HWPE to go idle, so the static HCI and periph muxes never switch mid-transaction.
- Sits between the cluster control registers and the hwpe_subsystem muxes and clock gates.

Parameters:
N_HWPES, 4, number of HWPEs (>=1)
SEL_W, 2, width of hwpe_sel_i/sel_o; must satisfy 2**SEL_W >= N_HWPES and SEL_W >= 1
MAX_OUTSTANDING, 4, max in-flight config reads/writes (>=1)
WAKE_CYCLES, 2, cycles clock runs before cfg traffic is admitted (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
hwpe_en_i  in  1  subsystem enable request
hwpe_sel_i  in  SEL_W  requested HWPE index
busy_i  in  N_HWPES  per-HWPE busy
cfg_req_i  in  1  config request from periph bus
cfg_gnt_o  out  1  grant back to periph bus
cfg_req_o  out  1  gated request to selected HWPE
cfg_gnt_i  in  1  grant from selected HWPE (already muxed by sel_o)
cfg_r_valid_i  in  1  response valid from selected HWPE
sel_o  out  SEL_W  registered active selection, drives all muxes
hwpe_clk_en_o  out  N_HWPES  one-hot clock enables
busy_o  out  1  subsystem busy
ready_o  out  1  high only in ACTIVE
sel_err_o  out  1  sticky: out-of-range select or response underflow

Behaviour:
Reset values (async, rst_n=0): state=OFF, sel_o=0, hwpe_clk_en_o=0, wake_cnt=0, outstanding=0, sel_err_o=0. All outputs are driven from these registers or from gating of inputs.

Request gating:
- cfg_req_o = cfg_req_i && state==ACTIVE && outstanding<MAX_OUTSTANDING.
- cfg_gnt_o = cfg_req_o && cfg_gnt_i. It is 0 in every other state, so the requester stalls.

Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
- +1 on cfg_gnt_o.
- -1 on cfg_r_valid_i.
- Both in the same cycle: no change.
- cfg_r_valid_i with outstanding==0: counter stays 0, sel_err_o set.

Select validity: a request is valid if hwpe_sel_i < N_HWPES. An out-of-range hwpe_sel_i sets sel_err_o and is treated as "no change" (the current selection is kept).

FSM:
- OFF: clk_en=0.
  - If hwpe_en_i && valid sel: latch sel_o=hwpe_sel_i, set hwpe_clk_en_o[sel]=1, wake_cnt=WAKE_CYCLES-1, go to WAKE.
- WAKE: clock enabled, no cfg traffic. Decrement wake_cnt; when it is 0, go to ACTIVE.
  - ACTIVE is first reached WAKE_CYCLES cycles after leaving OFF.
- ACTIVE: forward cfg traffic.
  - If !hwpe_en_i, or (valid sel && hwpe_sel_i != sel_o): go to DRAIN.
- DRAIN: block new requests. Outstanding responses still decrement the counter.
  - When outstanding==0 && !busy_i[sel_o]: go to GATE.
  - If the request reverts (hwpe_en_i && hwpe_sel_i==sel_o) before that: return to ACTIVE.
- GATE: clear hwpe_clk_en_o for exactly 1 cycle.
  - If hwpe_en_i && valid sel: latch new sel_o, enable its clock, go to WAKE.
  - Else: go to OFF.

Invariants:
- sel_o changes only on the OFF->WAKE or GATE->WAKE transition.
- hwpe_clk_en_o is one-hot or zero; never two bits set.
- hwpe_sel_i changing during WAKE is picked up on entering ACTIVE, which then goes to DRAIN.
- busy_o = (state is WAKE, DRAIN or GATE) || (state==ACTIVE && busy_i[sel_o]) || outstanding!=0.
- ready_o = state==ACTIVE.
- Reset mid-operation returns to OFF immediately, even with outstanding responses; responses arriving after reset are underflow and set sel_err_o.

Test Plan:
- Reset, then hwpe_en_i=1 with sel=2 (WAKE_CYCLES=2) -> sel_o=2, hwpe_clk_en_o=4'b0100 the next cycle, ready_o=1 two cycles later, cfg_gnt_o=0 during WAKE.
- ACTIVE on sel=0 with 4 granted, unanswered requests -> a 5th request is held (cfg_req_o=0); after one cfg_r_valid_i the next request is granted.
- Switch sel 0->1 while busy_i[0]=1 and 2 responses pending -> sel_o holds 0 until both responses arrive and busy drops; then 1 GATE cycle with clk_en=0; then sel_o=1, clk_en=4'b0010.
- hwpe_sel_i=5 with N_HWPES=4 during ACTIVE -> sel_err_o=1, sel_o unchanged, no DRAIN.
- In DRAIN, hwpe_sel_i returns to the old value -> back to ACTIVE with no clock-gate cycle; deassert hwpe_en_i instead -> DRAIN, GATE, OFF, all clk_en=0, busy_o=0.
- Assert rst_n=0 mid-DRAIN -> all outputs at reset values asynchronously; a later stray cfg_r_valid_i sets sel_err_o.
